// File: rtl/sram_req_ctrl_pkg.sv
// Shared types and response-buffer sizing for sram_req_ctrl.
// SRAM_REQ_SKID_EN selects a 2-entry response FIFO (1 entry otherwise).
package sram_req_ctrl_pkg;

  typedef enum logic {
    D16 = 1'b0,
    D32 = 1'b1
  } DWD_mode;

  typedef struct packed {
    logic    lsb;
    DWD_mode mode;
  } rsp_tag_t;

`ifdef SRAM_REQ_SKID_EN
  localparam int unsigned RSPDEPTH = 2;
`else
  localparam int unsigned RSPDEPTH = 1;
`endif

endpackage

// File: rtl/sram_req_ctrl_rsp_fifo.sv
// Small synchronous FIFO holding SRAM read responses until the consumer takes them.
module sram_rsp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0]     cnt
);

  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SLOTS = 2 ** PW;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [SLOTS];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : PW'(p + 1'b1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < int'(SLOTS); i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr      <= ptr_next(wptr);
      end
      if (pop) rptr <= ptr_next(rptr);
      case ({push, pop})
        2'b10:   cnt <= CW'(cnt + 1'b1);
        2'b01:   cnt <= CW'(cnt - 1'b1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head = mem[rptr];

endmodule

// File: rtl/sram_req_ctrl.sv
// Valid/ready front end for a one-cycle-latency two-port SRAM: read/write grants,
// same-word collision stall, response credit and D16 half-word selection.
module sram_req_ctrl
  import sram_req_ctrl_pkg::*;
#(
  parameter int unsigned WORDWD = 32,
  parameter int unsigned DWD    = 32,
  parameter int unsigned AWD    = $clog2(2 * WORDWD),
  parameter int unsigned SIZE   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  DWD_mode               i_dwd_mode,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  input  logic [AWD-1:0]        i_waddr,
  input  logic [DWD*SIZE-1:0]   i_wdata,
  input  logic                  i_rvalid,
  output logic                  o_rready,
  input  logic [AWD-1:0]        i_raddr,
  output logic                  o_rspvalid,
  input  logic                  i_rspready,
  output logic [DWD*SIZE-1:0]   o_rspdata,
  output logic                  o_sram_read,
  output logic                  o_sram_write,
  output logic [AWD-1:0]        o_sram_raddr,
  output logic [AWD-1:0]        o_sram_waddr,
  output logic [DWD*SIZE-1:0]   o_sram_wdata,
  input  logic [DWD*SIZE-1:0]   i_sram_rdata
);

  localparam int unsigned RFAWD = $clog2(WORDWD);
  localparam int unsigned HW    = DWD / 2;
  localparam int unsigned LW    = DWD * SIZE;
  localparam int unsigned CW    = $clog2(RSPDEPTH + 1);

  logic          inflight;
  rsp_tag_t      tag;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   occupancy;
  logic          rgnt;
  logic          wgnt;
  logic          pop;
  logic          collide;
  logic [LW-1:0] push_data;

  function automatic logic [RFAWD-1:0] word_idx(input logic [AWD-1:0] a, input DWD_mode m);
    return (m == D16) ? RFAWD'(a[AWD-1:1]) : a[RFAWD-1:0];
  endfunction

  // Grants, collision stall and credit; everything is held off during reset.
  always_comb begin
    occupancy = (CW+1)'(inflight) + (CW+1)'(fifo_cnt) - (CW+1)'(pop);
    o_rready  = !i_rst && (occupancy < (CW+1)'(RSPDEPTH));
    rgnt      = i_rvalid && o_rready;
    collide   = rgnt && i_wvalid &&
                (word_idx(i_raddr, i_dwd_mode) == word_idx(i_waddr, i_dwd_mode));
    o_wready  = !i_rst && !collide;
    wgnt      = i_wvalid && o_wready;
  end

  always_comb begin
    o_sram_read  = rgnt;
    o_sram_write = wgnt;
    o_sram_raddr = i_rst ? '0 : i_raddr;
    o_sram_waddr = i_rst ? '0 : i_waddr;
    o_sram_wdata = i_rst ? '0 : i_wdata;
  end

  // One read outstanding in the SRAM pipeline at most; reset drops it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      inflight <= 1'b0;
      tag      <= '{lsb: 1'b0, mode: D16};
    end else begin
      inflight <= rgnt;
      if (rgnt) tag <= '{lsb: i_raddr[0], mode: i_dwd_mode};
    end
  end

  // D16 responses carry the addressed half, zero-extended, in every lane.
  always_comb begin
    push_data = '0;
    for (int l = 0; l < int'(SIZE); l++) begin
      if (tag.mode == D16)
        push_data[l*DWD +: DWD] = DWD'(tag.lsb ? i_sram_rdata[l*DWD+HW +: HW]
                                               : i_sram_rdata[l*DWD +: HW]);
      else
        push_data[l*DWD +: DWD] = i_sram_rdata[l*DWD +: DWD];
    end
  end

  assign o_rspvalid = (fifo_cnt != '0);
  assign pop        = o_rspvalid && i_rspready;

  sram_rsp_fifo #(
    .DEPTH (RSPDEPTH),
    .WIDTH (LW)
  ) u_fifo (
    .clk  (i_clk),
    .rst  (i_rst),
    .push (inflight),
    .pop  (pop),
    .din  (push_data),
    .head (o_rspdata),
    .cnt  (fifo_cnt)
  );

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed self-checking bench for sram_req_ctrl with a behavioural two-port SRAM.
module tb_sram_req_ctrl;
  import sram_req_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  DWD_mode     mode;
  logic        wvalid, wready, rvalid, rready, rspvalid, rspready;
  logic [5:0]  waddr, raddr, sram_raddr, sram_waddr;
  logic [31:0] wdata, rspdata, sram_wdata, sram_rdata;
  logic        sram_read, sram_write;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [32];

  always #5 clk = ~clk;

  sram_req_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_dwd_mode(mode),
    .i_wvalid(wvalid), .o_wready(wready), .i_waddr(waddr), .i_wdata(wdata),
    .i_rvalid(rvalid), .o_rready(rready), .i_raddr(raddr),
    .o_rspvalid(rspvalid), .i_rspready(rspready), .o_rspdata(rspdata),
    .o_sram_read(sram_read), .o_sram_write(sram_write),
    .o_sram_raddr(sram_raddr), .o_sram_waddr(sram_waddr),
    .o_sram_wdata(sram_wdata), .i_sram_rdata(sram_rdata)
  );

  function automatic logic [4:0] widx(input logic [5:0] a, input DWD_mode m);
    return (m == D16) ? a[5:1] : a[4:0];
  endfunction

  // Memory model: write at the grant edge, read data one cycle later, X on same-word collision.
  always @(posedge clk) begin
    if (sram_write) mem[widx(sram_waddr, mode)] <= sram_wdata;
    if (sram_read)
      sram_rdata <= (sram_write && widx(sram_waddr, mode) == widx(sram_raddr, mode))
                    ? 32'hxxxxxxxx : mem[widx(sram_raddr, mode)];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    wvalid = 1'b1; waddr = a; wdata = d;
    tick();
    wvalid = 1'b0;
  endtask

  // Single read from an idle controller: granted now, response exactly two cycles later.
  task automatic rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
    rvalid = 1'b1; raddr = a;
    #1 check({tag, "_rready"}, rready, 1);
    tick();
    rvalid = 1'b0;
    #1 check({tag, "_not_yet"}, rspvalid, 0);
    tick();
    #1 check({tag, "_valid"}, rspvalid, 1);
    check({tag, "_data"}, rspdata, exp);
    tick();
  endtask

  int idx;
  int got;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    sram_rdata = '0;
    rst = 1'b1; mode = D32;
    wvalid = 0; waddr = 0; wdata = 0; rvalid = 0; raddr = 0; rspready = 1'b1;
    tick(); tick();
    rvalid = 1'b1; raddr = 6'd5; wvalid = 1'b1; waddr = 6'd3; wdata = 32'hFFFF_FFFF;
    #1 check("rst_rready", rready, 0);
    check("rst_wready", wready, 0);
    check("rst_sram_read", sram_read, 0);
    check("rst_sram_write", sram_write, 0);
    check("rst_rspvalid", rspvalid, 0);
    rvalid = 0; wvalid = 0;
    tick();
    rst = 1'b0;
    #1 check("post_rst_rready", rready, 1);

    // D32 write then read one cycle later
    wvalid = 1'b1; waddr = 6'd5; wdata = 32'hDEAD_BEEF;
    #1 check("w5_wready", wready, 1);
    check("w5_sram_write", sram_write, 1);
    check("w5_sram_waddr", sram_waddr, 5);
    tick();
    wvalid = 1'b0;
    rd("d32_r5", 6'd5, 32'hDEAD_BEEF);
    #1 check("d32_drained", rspvalid, 0);

    // Reset asserted while a read is in flight
    rvalid = 1'b1; raddr = 6'd5;
    tick();
    rst = 1'b1; wvalid = 1'b1; waddr = 6'd7; wdata = 32'h5555_AAAA;
    #1 check("mid_rst_rready", rready, 0);
    check("mid_rst_wready", wready, 0);
    check("mid_rst_sram_read", sram_read, 0);
    check("mid_rst_sram_write", sram_write, 0);
    check("mid_rst_sram_raddr", sram_raddr, 0);
    check("mid_rst_sram_waddr", sram_waddr, 0);
    check("mid_rst_sram_wdata", sram_wdata, 0);
    check("mid_rst_rspvalid", rspvalid, 0);
    check("mid_rst_rspdata", rspdata, 0);
    tick();
    rst = 1'b0; rvalid = 1'b0; wvalid = 1'b0;
    #1 check("rel_rready", rready, 1);
    tick();
    #1 check("no_stale_rsp1", rspvalid, 0);
    tick();
    #1 check("no_stale_rsp2", rspvalid, 0);

    // D16 half-word selection on word 3
    wr(6'd3, 32'h1234_ABCD);
    mode = D16;
    rd("d16_lo", 6'd6, 32'h0000_ABCD);
    rd("d16_hi", 6'd7, 32'h0000_1234);
    mode = D32;

    // Same-word collision: read wins, write follows next cycle
    wr(6'd9, 32'h1111_1111);
    rvalid = 1'b1; raddr = 6'd9; wvalid = 1'b1; waddr = 6'd9; wdata = 32'h2222_2222;
    #1 check("coll_wready", wready, 0);
    check("coll_sram_write", sram_write, 0);
    check("coll_sram_read", sram_read, 1);
    tick();
    rvalid = 1'b0;
    #1 check("coll_w_retry", wready, 1);
    check("coll_w_sram_write", sram_write, 1);
    tick();
    wvalid = 1'b0;
    #1 check("coll_old_valid", rspvalid, 1);
    check("coll_old_data", rspdata, 32'h1111_1111);
    tick();
    rd("coll_new", 6'd9, 32'h2222_2222);

    // Different words in the same cycle do not stall the write
    rvalid = 1'b1; raddr = 6'd9; wvalid = 1'b1; waddr = 6'd10; wdata = 32'h3333_3333;
    #1 check("nocoll_wready", wready, 1);
    tick();
    rvalid = 1'b0; wvalid = 1'b0;
    tick();
    #1 check("nocoll_rdata", rspdata, 32'h2222_2222);
    tick();
    rd("nocoll_w10", 6'd10, 32'h3333_3333);

    for (int i = 0; i < 8; i++) wr(6'(i), 32'hC0DE_0000 + 32'(i));

`ifdef SRAM_REQ_SKID_EN
    // Stream 8 reads against alternating backpressure
    idx = 0; got = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      rspready = (c % 2 == 0);
      rvalid = (idx < 8); raddr = 6'(idx);
      #1;
      check("skid_cnt_bound", dut.fifo_cnt <= 2, 1);
      if (rspvalid && rspready) begin
        check("skid_data", rspdata, 32'hC0DE_0000 + 32'(got));
        got++;
      end
      if (rvalid && rready) idx++;
      tick();
    end
    rvalid = 1'b0; rspready = 1'b1;
    check("skid_count", got, 8);
    tick();
    #1 check("skid_no_dup", rspvalid, 0);
`else
    // Stream 4 reads: one grant and one response every other cycle
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      rvalid = (idx < 4); raddr = 6'(idx);
      #1;
      check("thru_rready", rready, (c % 2 == 0) || (c == 9));
      check("thru_rspvalid", rspvalid, (c >= 2) && (c % 2 == 0));
      if (rspvalid) check("thru_data", rspdata, 32'hC0DE_0000 + 32'(c / 2 - 1));
      if (rvalid && rready) idx++;
      tick();
    end
    rvalid = 1'b0;
    check("thru_issued", idx, 4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
